led_pattern_ctrl: RTL

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pattern_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: runs one of four 4-bit patterns, each step held
// for STEP_CYCLES clocks, for a fixed step count or until aborted.
module led_pattern_ctrl #(
  parameter int unsigned STEP_CYCLES = 6000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_mode,
  input  logic [7:0] i_cmd_steps,
  input  logic       i_abort,
  output logic [3:0] o_led,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] M_BINARY = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  localparam logic [31:0] PRESC_LAST = 32'(STEP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  steps_q, steps_d;
  logic [31:0] presc_q, presc_d;
  logic [7:0]  idx_q, idx_d;
  logic [2:0]  phase_q, phase_d;
  logic        done_q, done_d;

  logic        wrap;
  logic        last;
  logic [3:0]  pat;

  assign wrap = (presc_q == PRESC_LAST);
  // steps_q == 0 means free-running, so it never matches a last step
  assign last = (steps_q != 8'd0) && (idx_q == steps_q - 8'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      steps_q <= 8'd0;
      presc_q <= 32'd0;
      idx_q   <= 8'd0;
      phase_q <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    steps_d = steps_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          state_d = RUN;
          mode_d  = i_cmd_mode;
          steps_d = i_cmd_steps;
          presc_d = 32'd0;
          idx_d   = 8'd0;
          phase_d = 3'd0;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (wrap && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wrap) begin
          presc_d = 32'd0;
          idx_d   = idx_q + 8'd1;
          phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat = 4'b0000;
    case (mode_q)
      M_BINARY: pat = idx_q[3:0];
      M_CHASE:  pat = 4'b0001 << idx_q[1:0];
      M_BOUNCE: begin
        case (phase_q)
          3'd0:    pat = 4'b0001;
          3'd1:    pat = 4'b0010;
          3'd2:    pat = 4'b0100;
          3'd3:    pat = 4'b1000;
          3'd4:    pat = 4'b0100;
          3'd5:    pat = 4'b0010;
          default: pat = 4'b0001;
        endcase
      end
      M_BLINK:  pat = idx_q[0] ? 4'b0000 : 4'b1111;
      default:  pat = 4'b0000;
    endcase
  end

  assign o_led       = (state_q == RUN) ? pat : 4'b0000;
  assign o_busy      = (state_q == RUN);
  assign o_cmd_ready = (state_q == IDLE);
  assign o_done      = done_q;

endmodule
